// File: rtl/modulo_adder_pipe_if.sv
// Operand/result bus for modulo_adder_pipe.
interface modulo_adder_pipe_if #(
  parameter int WIDTH = 7
);
  // Handshake: a transfer happens on a rising clk edge when valid and ready
  // are both 1 on the same side. A producer holds its valid and payload
  // steady until that edge. Ready may depend combinationally on the
  // consumer's state, and in_ready follows out_ready within the same cycle.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] k;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             wrap;

  // Environment side: supplies operations and accepts results
  modport master (
    output in_valid, a, b, k, out_ready,
    input  in_ready, out_valid, s, wrap
  );

  // Adder side
  modport slave (
    input  in_valid, a, b, k, out_ready,
    output in_ready, out_valid, s, wrap
  );
endinterface

// File: rtl/modulo_adder_pipe.sv
// Three-stage pipelined modulo adder: s = (a + b) mod (2^WIDTH - k).
// Stage 1 forms generate/propagate terms for a+b and for the carry-save
// form of a+b+k. Stage 2 runs a Kogge-Stone prefix on both chains. Stage 3
// picks the k-corrected sum whenever a+b+k carries out of WIDTH bits.
module modulo_adder_pipe #(
  parameter int WIDTH = 7
) (
  input logic                clk,
  input logic                reset,
  modulo_adder_pipe_if.slave bus
);

  // Kogge-Stone prefix. Returns the carry into each bit position with a
  // carry-in of 0, so bit 0 is always 0 and bit i is the group generate of
  // bits [i-1:0].
  function automatic logic [WIDTH-1:0] ks_cin(input logic [WIDTH-1:0] g_in,
                                              input logic [WIDTH-1:0] p_in);
    logic [WIDTH-1:0] g_lvl;
    logic [WIDTH-1:0] p_lvl;
    logic [WIDTH-1:0] g_nxt;
    logic [WIDTH-1:0] p_nxt;
    g_lvl = g_in;
    p_lvl = p_in;
    for (int d = 1; d < WIDTH; d = d * 2) begin
      g_nxt = g_lvl;
      p_nxt = p_lvl;
      for (int i = d; i < WIDTH; i++) begin
        g_nxt[i] = g_lvl[i] | (p_lvl[i] & g_lvl[i-d]);
        p_nxt[i] = p_lvl[i] & p_lvl[i-d];
      end
      g_lvl = g_nxt;
      p_lvl = p_nxt;
    end
    return {g_lvl[WIDTH-2:0], 1'b0};
  endfunction

  // Flow control: a stage may load when it is empty or its content moves on.
  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;

  assign adv3         = bus.out_ready || !v3_q;
  assign adv2         = !v2_q || adv3;
  assign adv1         = !v1_q || adv2;
  assign bus.in_ready = adv1;

  // Stage 1 combinational: plain g/p and carry-save a+b+k terms
  logic [WIDTH-1:0] x_d, maj_d, y_lo_d;
  logic [WIDTH-1:0] g_d, p_d, gp_d, pp_d;

  assign x_d    = bus.a ^ bus.b ^ bus.k;
  assign maj_d  = (bus.a & bus.b) | (bus.a & bus.k) | (bus.b & bus.k);
  assign y_lo_d = {maj_d[WIDTH-2:0], 1'b0};
  assign g_d    = bus.a & bus.b;
  assign p_d    = bus.a ^ bus.b;
  assign gp_d   = x_d & y_lo_d;
  assign pp_d   = x_d ^ y_lo_d;

  logic [WIDTH-1:0] g_q, p_q, h_q, gp_q, pp_q, hp_q;
  logic             ym1_q;

  // Stage 1 register: preprocessed terms plus the carry-save overflow bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1_q  <= 1'b0;
      g_q   <= '0;
      p_q   <= '0;
      h_q   <= '0;
      gp_q  <= '0;
      pp_q  <= '0;
      hp_q  <= '0;
      ym1_q <= 1'b0;
    end else if (adv1) begin
      v1_q  <= bus.in_valid;
      g_q   <= g_d;
      p_q   <= p_d;
      h_q   <= p_d;
      gp_q  <= gp_d;
      pp_q  <= pp_d;
      hp_q  <= pp_d;
      ym1_q <= maj_d[WIDTH-1];
    end
  end

  // Stage 2 combinational: prefix carries on both chains
  logic [WIDTH-1:0] c_d, cp_d;
  logic             coutp_d;

  assign c_d     = ks_cin(g_q, p_q);
  assign cp_d    = ks_cin(gp_q, pp_q);
  // Carry out of the MSB of the k-corrected chain: one more prefix cell
  assign coutp_d = gp_q[WIDTH-1] | (pp_q[WIDTH-1] & cp_d[WIDTH-1]);

  logic [WIDTH-1:0] c_q, cp_q, h2_q, hp2_q;
  logic             coutp_q, ym2_q;

  // Stage 2 register: carry vectors, half-sums and overflow indicators
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v2_q    <= 1'b0;
      c_q     <= '0;
      cp_q    <= '0;
      h2_q    <= '0;
      hp2_q   <= '0;
      coutp_q <= 1'b0;
      ym2_q   <= 1'b0;
    end else if (adv2) begin
      v2_q    <= v1_q;
      c_q     <= c_d;
      cp_q    <= cp_d;
      h2_q    <= h_q;
      hp2_q   <= hp_q;
      coutp_q <= coutp_d;
      ym2_q   <= ym1_q;
    end
  end

  // Stage 3 combinational: a+b >= M exactly when a+b+k overflows WIDTH bits
  logic [WIDTH-1:0] s0_d, s1_d, s_d;
  logic             wrap_d;

  assign s0_d   = h2_q ^ c_q;
  assign s1_d   = hp2_q ^ cp_q;
  assign wrap_d = ym2_q | coutp_q;
  assign s_d    = wrap_d ? s1_d : s0_d;

  logic [WIDTH-1:0] s_q;
  logic             wrap_q;

  // Stage 3 register: selected result, held while downstream stalls
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v3_q   <= 1'b0;
      s_q    <= '0;
      wrap_q <= 1'b0;
    end else if (adv3) begin
      v3_q   <= v2_q;
      s_q    <= s_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out_valid = v3_q;
  assign bus.s         = s_q;
  assign bus.wrap      = wrap_q;

endmodule

// File: tb/tb_modulo_adder_pipe.sv
// Bench for modulo_adder_pipe: a 7-bit and a 16-bit instance on one clock
// and reset. Each cycle: drive on the falling edge, sample 1 ns later.
module tb_modulo_adder_pipe;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [7:0]  exp7_q[$];
  logic [16:0] exp16_q[$];

  // Clock and reset
  always #5 clk = ~clk;

  modulo_adder_pipe_if #(.WIDTH(7))  bus7();
  modulo_adder_pipe_if #(.WIDTH(16)) bus16();

  modulo_adder_pipe #(.WIDTH(7)) dut7 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus7)
  );

  modulo_adder_pipe #(.WIDTH(16)) dut16 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus16)
  );

  // Reference: {wrap, (a+b) mod (2^W - k)}
  function automatic logic [7:0] ref7(input int a, input int b, input int k);
    int m;
    int sum;
    m   = 128 - k;
    sum = a + b;
    if (sum >= m) return {1'b1, 7'(sum - m)};
    return {1'b0, 7'(sum)};
  endfunction

  function automatic logic [16:0] ref16(input int a, input int b, input int k);
    int m;
    int sum;
    m   = 65536 - k;
    sum = a + b;
    if (sum >= m) return {1'b1, 16'(sum - m)};
    return {1'b0, 16'(sum)};
  endfunction

  // Driver tasks: one cycle each
  task automatic drive7(input bit iv, input int a, input int b, input int k, input bit ordy);
    @(negedge clk);
    bus7.in_valid  = iv;
    bus7.a         = 7'(a);
    bus7.b         = 7'(b);
    bus7.k         = 7'(k);
    bus7.out_ready = ordy;
    #1;
  endtask

  task automatic drive16(input bit iv, input int a, input int b, input int k, input bit ordy);
    @(negedge clk);
    bus16.in_valid  = iv;
    bus16.a         = 16'(a);
    bus16.b         = 16'(b);
    bus16.k         = 16'(k);
    bus16.out_ready = ordy;
    #1;
  endtask

  // One isolated op on the 7-bit unit. Presented in cycle t, the result must
  // first be visible in cycle t+3 (after the third rising edge counting the
  // accepting one).
  task automatic run_op7(input string name, input int a, input int b, input int k,
                         input int exp_s, input int exp_w);
    int edges;
    bit seen;
    drive7(1'b1, a, b, k, 1'b1);
    checks++;
    if (bus7.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_in_ready got %b want 1", name, bus7.in_ready);
    end
    drive7(1'b0, 0, 0, 0, 1'b1);
    edges = 1;
    seen  = 1'b0;
    while (!seen && edges <= 6) begin
      if (bus7.out_valid === 1'b1) seen = 1'b1;
      else begin
        drive7(1'b0, 0, 0, 0, 1'b1);
        edges++;
      end
    end
    checks++;
    if (edges != 3) begin
      errors++;
      $display("FAIL %s_latency got %0d edges want 3", name, edges);
    end
    checks++;
    if ({bus7.wrap, bus7.s} !== {1'(exp_w), 7'(exp_s)}) begin
      errors++;
      $display("FAIL %s_result got s=%0d wrap=%b want s=%0d wrap=%0d",
               name, bus7.s, bus7.wrap, exp_s, exp_w);
    end
    drive7(1'b0, 0, 0, 0, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive7(1'b0, 0, 0, 0, 1'b1);
    drive16(1'b0, 0, 0, 0, 1'b1);
    checks++;
    if ({bus7.out_valid, bus7.wrap, bus7.s, bus7.in_ready} !== {1'b0, 1'b0, 7'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset7 got v=%b w=%b s=%0d rdy=%b want v=0 w=0 s=0 rdy=1",
               bus7.out_valid, bus7.wrap, bus7.s, bus7.in_ready);
    end
    checks++;
    if ({bus16.out_valid, bus16.wrap, bus16.s, bus16.in_ready} !== {1'b0, 1'b0, 16'd0, 1'b1}) begin
      errors++;
      $display("FAIL reset16 got v=%b w=%b s=%0d rdy=%b want v=0 w=0 s=0 rdy=1",
               bus16.out_valid, bus16.wrap, bus16.s, bus16.in_ready);
    end
    rst_n = 1'b1;
  endtask

  // M = 24
  task automatic test_mod24();
    run_op7("m24_10_9", 10, 9, 104, 19, 0);
    run_op7("m24_20_15", 20, 15, 104, 11, 1);
    run_op7("m24_23_1", 23, 1, 104, 0, 1);
  endtask

  // k = 0: plain mod-128 addition, wrap is the carry-out
  task automatic test_k0();
    run_op7("k0_100_50", 100, 50, 0, 22, 1);
    run_op7("k0_3_4", 3, 4, 0, 7, 0);
  endtask

  task automatic test_back_to_back();
    int sent, got, cyc, first, last;
    int ca, cb, ck;
    logic [7:0] e;
    sent = 0; got = 0; cyc = 0; first = -1; last = -1;
    ck = $urandom_range(0, 127);
    ca = $urandom_range(0, 127 - ck);
    cb = $urandom_range(0, 127 - ck);
    while (got < 20 && cyc < 200) begin
      drive7(sent < 20, ca, cb, ck, 1'b1);
      if (bus7.out_valid === 1'b1) begin
        checks++;
        if (exp7_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra got s=%0d with nothing expected", bus7.s);
        end else begin
          e = exp7_q.pop_front();
          if ({bus7.wrap, bus7.s} !== e) begin
            errors++;
            $display("FAIL b2b_result got s=%0d wrap=%b want s=%0d wrap=%b",
                     bus7.s, bus7.wrap, e[6:0], e[7]);
          end
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (bus7.in_valid && bus7.in_ready) begin
        exp7_q.push_back(ref7(ca, cb, ck));
        sent++;
        ck = $urandom_range(0, 127);
        ca = $urandom_range(0, 127 - ck);
        cb = $urandom_range(0, 127 - ck);
      end
      cyc++;
    end
    bus7.in_valid = 1'b0;
    checks++;
    if (got != 20) begin
      errors++;
      $display("FAIL b2b_count got %0d want 20", got);
    end
    checks++;
    if (last - first != 19) begin
      errors++;
      $display("FAIL b2b_span got %0d cycles want 19", last - first);
    end
  endtask

  task automatic test_stall();
    int av[5], bv[5], es[5], ew[5];
    int idx, got, cyc;
    bit ordy;
    av = '{10, 20, 23, 5, 12};
    bv = '{9, 15, 1, 7, 12};
    es = '{19, 11, 0, 12, 0};
    ew = '{0, 1, 1, 0, 1};
    idx = 0; got = 0; cyc = 0;
    while (got < 5 && cyc < 40) begin
      ordy = (cyc >= 6);
      if (idx < 5) drive7(1'b1, av[idx], bv[idx], 104, ordy);
      else drive7(1'b0, 0, 0, 0, ordy);
      if (cyc < 6) begin
        checks++;
        if (bus7.in_ready !== 1'(cyc < 3)) begin
          errors++;
          $display("FAIL stall_in_ready cyc %0d got %b want %b", cyc, bus7.in_ready, cyc < 3);
        end
      end
      if (cyc >= 3 && cyc < 6) begin
        checks++;
        if ({bus7.out_valid, bus7.wrap, bus7.s} !== {1'b1, 1'b0, 7'd19}) begin
          errors++;
          $display("FAIL stall_hold cyc %0d got v=%b s=%0d wrap=%b want v=1 s=19 wrap=0",
                   cyc, bus7.out_valid, bus7.s, bus7.wrap);
        end
      end
      if (bus7.out_valid === 1'b1 && ordy) begin
        checks++;
        if ({bus7.wrap, bus7.s} !== {1'(ew[got]), 7'(es[got])} || cyc != 6 + got) begin
          errors++;
          $display("FAIL stall_drain op %0d got s=%0d wrap=%b cyc %0d want s=%0d wrap=%0d cyc %0d",
                   got, bus7.s, bus7.wrap, cyc, es[got], ew[got], 6 + got);
        end
        got++;
      end
      if (bus7.in_valid && bus7.in_ready) idx++;
      cyc++;
    end
    bus7.in_valid = 1'b0;
    checks++;
    if (got != 5) begin
      errors++;
      $display("FAIL stall_count got %0d want 5", got);
    end
  endtask

  task automatic test_reset_mid();
    drive7(1'b1, 10, 9, 104, 1'b1);
    drive7(1'b1, 20, 15, 104, 1'b1);
    drive7(1'b1, 1, 2, 104, 1'b1);
    drive7(1'b0, 0, 0, 0, 1'b1);
    checks++;
    if ({bus7.out_valid, bus7.s} !== {1'b1, 7'd19}) begin
      errors++;
      $display("FAIL rstmid_pre got v=%b s=%0d want v=1 s=19", bus7.out_valid, bus7.s);
    end
    // Mid-cycle, well away from any rising edge
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus7.out_valid, bus7.wrap, bus7.s, bus7.in_ready} !== {1'b0, 1'b0, 7'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async got v=%b w=%b s=%0d rdy=%b want v=0 w=0 s=0 rdy=1",
               bus7.out_valid, bus7.wrap, bus7.s, bus7.in_ready);
    end
    drive7(1'b0, 0, 0, 0, 1'b1);
    drive7(1'b0, 0, 0, 0, 1'b1);
    rst_n = 1'b1;
    run_op7("rstmid_new", 5, 6, 104, 11, 0);
  endtask

  task automatic test_w16();
    int ca_v[4], cb_v[4], ce_s[4], ce_w[4];
    int sent, got, cyc, ca, cb;
    bit iv, ordy;
    logic [16:0] e;
    ca_v = '{65520, 0, 65520, 65520};
    cb_v = '{65520, 0, 1, 0};
    ce_s = '{65519, 0, 0, 65520};
    ce_w = '{1, 0, 1, 0};
    sent = 0; got = 0; cyc = 0;
    ca = ca_v[0]; cb = cb_v[0];
    while (got < 1004 && cyc < 8000) begin
      iv   = (sent < 1004) && ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) != 0);
      drive16(iv, ca, cb, 15, ordy);
      if (bus16.out_valid === 1'b1 && ordy) begin
        checks++;
        if (exp16_q.size() == 0) begin
          errors++;
          $display("FAIL w16_extra got s=%0d with nothing expected", bus16.s);
        end else begin
          e = exp16_q.pop_front();
          if ({bus16.wrap, bus16.s} !== e) begin
            errors++;
            $display("FAIL w16_result op %0d got s=%0d wrap=%b want s=%0d wrap=%b",
                     got, bus16.s, bus16.wrap, e[15:0], e[16]);
          end
        end
        got++;
      end
      if (bus16.in_valid && bus16.in_ready) begin
        if (sent < 4) exp16_q.push_back({1'(ce_w[sent]), 16'(ce_s[sent])});
        else exp16_q.push_back(ref16(ca, cb, 15));
        sent++;
        if (sent < 4) begin
          ca = ca_v[sent];
          cb = cb_v[sent];
        end else begin
          ca = $urandom_range(0, 65520);
          cb = $urandom_range(0, 65520);
        end
      end
      cyc++;
    end
    bus16.in_valid = 1'b0;
    checks++;
    if (got != 1004 || exp16_q.size() != 0) begin
      errors++;
      $display("FAIL w16_count got %0d left %0d want 1004 left 0", got, exp16_q.size());
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    bus7.in_valid   = 1'b0;
    bus7.a          = '0;
    bus7.b          = '0;
    bus7.k          = '0;
    bus7.out_ready  = 1'b1;
    bus16.in_valid  = 1'b0;
    bus16.a         = '0;
    bus16.b         = '0;
    bus16.k         = '0;
    bus16.out_ready = 1'b1;
    test_reset();
    test_mod24();
    test_k0();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    test_w16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/modulo_adder_pipe.md
# modulo_adder_pipe

Parametrised, pipelined modulo adder. Computes s = (a + b) mod M, where M = 2^WIDTH − k, using the three-stage datapath:

- preprocessing (g/p/h and primed g′/p′/h′);
- Kogge-Stone parallel-prefix carry computation on both chains;
- sum selection.

Stages are separated by registers with valid/ready flow control, so the block sustains one operation per cycle under backpressure. It replaces the combinational fixed-7-bit adder chain as the arithmetic unit feeding downstream modular-arithmetic logic.

## Interface
- WIDTH, 7, operand/result width in bits (≥2)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset; clears all pipeline state
- in_valid  in  1  input operation present
- in_ready  out  1  block accepts input this cycle
- a  in  WIDTH  addend, expected < M
- b  in  WIDTH  addend, expected < M
- k  in  WIDTH  modulus correction, k = 2^WIDTH − M, per-operation
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result this cycle
- s  out  WIDTH  (a + b) mod M
- wrap  out  1  1 when a + b ≥ M (the k-corrected sum was selected)

## Operation
- Transfer occurs on a rising clk edge when valid && ready on the same interface.
- **Stage 1 (preprocess)**
  - g = a & b, p = a ^ b, h = a ^ b.
  - Carry-save a + b + k: x = a ^ b ^ k, y = {maj(a,b,k), 1'b0} (WIDTH+1 bits).
  - g′ = x & y[WIDTH-1:0], p′ = x ^ y[WIDTH-1:0], h′ = p′.
  - Register g, p, h, g′, p′, h′, y[WIDTH].
- **Stage 2 (prefix)**
  - Kogge-Stone, ceil(log2 WIDTH) levels, combinational within the stage, on both (g,p) and (g′,p′). Carry-in 0.
  - Produces carry vectors c, c′ and carry-outs cout, cout′.
  - Register c, c′, h, h′, cout′, y[WIDTH].
- **Stage 3 (sum select)**
  - s0 = h ^ {c[WIDTH-2:0], 0}; s1 = h′ ^ {c′[WIDTH-2:0], 0}.
  - wrap = y[WIDTH] | cout′.
  - s = wrap ? s1 : s0.
  - Register s, wrap.
- **Arithmetic rules**
  - s1 equals (a + b + k) mod 2^WIDTH; s0 equals (a + b) mod 2^WIDTH.
  - For in-range operands (a, b < M, 1 ≤ M ≤ 2^WIDTH), s ∈ [0, M−1].
  - k = 0 gives plain mod-2^WIDTH addition; wrap is then the carry-out.
  - Out-of-range operands are not flagged. The result follows the formulas above exactly.
- **Flow control**
  - Each stage register i has valid bit v_i.
  - advance_3 = out_ready || !v_3.
  - advance_i = !v_i || advance_{i+1}, for i = 1, 2.
  - in_ready = advance_1.
  - Stage data loads only when its advance is 1; otherwise it holds.
  - Results are delivered in order; no operation is dropped or duplicated.
- **Reset (reset = 0)**
  - v_1..v_3 = 0 immediately (asynchronous). Any in-flight operations are discarded.
  - Outputs: out_valid = 0, s = 0, wrap = 0.
  - in_ready = 1 once all v_i = 0. It is combinational and is 1 throughout reset.

## Timing
- Latency: an input accepted at edge n gives out_valid = 1 after edge n+3, when the pipeline is not stalled.
- Throughput: 1 op/cycle while out_ready = 1.
- Stall: with out_ready held at 0, the pipeline fills after 3 accepted ops.
  - in_ready drops to 0 in the same cycle the 4th op is presented.
  - Stage 3 data (s, wrap) stays stable while out_valid && !out_ready.
- Simultaneous events:
  - Stage 3 output transfer and a new stage 3 load on the same edge is legal. The new data replaces the old.
  - in_ready is combinational from out_ready (no skid buffer).
- Reset release: the first input can be accepted on the first rising edge after reset deasserts.

## Test plan
- WIDTH=7, k=104 (M=24):
  - a=10, b=9 → s=19, wrap=0, out_valid 3 cycles after acceptance.
  - a=20, b=15 → s=11, wrap=1.
  - a=23, b=1 → s=0, wrap=1.
- WIDTH=7, k=0:
  - a=100, b=50 → s=22, wrap=1.
  - a=3, b=4 → s=7, wrap=0.
- Back-to-back streaming of 20 random in-range ops (random k per op) with out_ready=1 → one result per cycle, in order, each matching (a+b) mod M.
- out_ready=0 for 6 cycles while in_valid=1 with ops A–E → A, B, C accepted; in_ready=0 from the 4th presentation; s/wrap of A held stable. After out_ready=1: A–E emerge in order with no gaps or duplicates.
- reset asserted mid-stream with 3 ops in flight → out_valid=0, s=0, wrap=0 immediately, without waiting for a clock edge. After release, no stale result appears; a new op a=5, b=6, k=104 → s=11 after 3 cycles.
- WIDTH=16, k=15 (M=65521), 1000 random in-range ops plus corner cases a=b=M−1 → s=65519, wrap=1 → all results match the reference model.
